// File: rtl/fsqrt_operand_gen.sv
// fsqrt_operand_gen
//   Self-running operand source for the fsqrt test harness. After start it
//   emits three groups of single-precision operands, one per cycle:
//     SPECIAL : fixed table of corner values
//     SWEEP   : for e = 1..254, {0,e,0} then {0,e,7FFFFF}
//     RANDOM  : RAND_COUNT operands from a 32-bit Galois LFSR
//   A LATENCY-deep delay line re-times op/op_valid so debug capture can pair
//   each operand with the fsqrt result produced for it.
//
//   Optional build macro: FSQRT_GEN_NEG_EN
//     Adds -1.0 and -inf to the SPECIAL table and takes the RANDOM sign
//     bit from lfsr[31]. When undefined, all SWEEP/RANDOM operands are
//     positive and the table holds 8 entries.
//
// Ports
//   clk           system clock
//   reset         asynchronous reset, active-low
//   start         level; begins a full run when sampled in IDLE/DONE
//   hold          stall; freezes the generator while high (not in IDLE/DONE)
//   op            current operand {sign, exp[7:0], fra[22:0]}
//   op_valid      op is a new operand this cycle
//   op_aligned    op delayed by LATENCY cycles
//   aligned_valid op_valid delayed by LATENCY cycles
//   phase         0 IDLE/DONE, 1 SPECIAL, 2 SWEEP, 3 RANDOM
//   count         operands emitted since the last start (16-bit wrap)
//   done          high in DONE
module fsqrt_operand_gen #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned RAND_COUNT = 1024,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  output logic [31:0] op,
  output logic        op_valid,
  output logic [31:0] op_aligned,
  output logic        aligned_valid,
  output logic [1:0]  phase,
  output logic [15:0] count,
  output logic        done
);

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
`ifdef FSQRT_GEN_NEG_EN
  localparam logic [3:0]  SPEC_LAST = 4'd9;
`else
  localparam logic [3:0]  SPEC_LAST = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_SWEEP,
    S_RANDOM,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx;        // index of the SPECIAL entry currently on op
  logic [7:0]  sexp;       // exponent of the SWEEP operand currently on op
  logic        half;       // 0: fraction all-zero, 1: fraction all-ones
  logic [15:0] rcnt;       // RANDOM operands emitted so far, including op
  logic [31:0] lfsr, lfsr_nxt;
  logic [31:0] rand_op;
  logic [31:0] op_nxt;

  logic        running, adv, launch;
  logic        spec_last, sweep_last, rand_last, lfsr_step;

  logic [31:0] dly_op [LATENCY];
  logic [LATENCY-1:0] dly_v;

  function automatic logic [31:0] spec_entry(input logic [3:0] i);
    logic [31:0] v;
    case (i)
      4'd0:    v = 32'h00000000;
      4'd1:    v = 32'h80000000;
      4'd2:    v = 32'h7F800000;
      4'd3:    v = 32'h7FC00000;
      4'd4:    v = 32'h3F800000;
      4'd5:    v = 32'h40800000;
      4'd6:    v = 32'h00800000;
      4'd7:    v = 32'h7F7FFFFF;
`ifdef FSQRT_GEN_NEG_EN
      4'd8:    v = 32'hBF800000;
      4'd9:    v = 32'hFF800000;
`endif
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  // Right-shifting Galois LFSR: feedback taken from the bit shifted out.
  always_comb begin
    lfsr_nxt = lfsr >> 1;
    if (lfsr[0]) lfsr_nxt = (lfsr >> 1) ^ LFSR_MASK;
  end

`ifdef FSQRT_GEN_NEG_EN
  assign rand_op = lfsr;
`else
  assign rand_op = {1'b0, lfsr[30:0]};
`endif

  assign running    = (state == S_SPECIAL) || (state == S_SWEEP) || (state == S_RANDOM);
  assign adv        = running && !hold;
  assign launch     = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign spec_last  = (idx == SPEC_LAST);
  assign sweep_last = half && (sexp == 8'd254);
  assign rand_last  = (rcnt == 16'(RAND_COUNT));
  // LFSR steps only when an operand is taken from it (first RANDOM op
  // leaves SWEEP, later ones stay in RANDOM).
  assign lfsr_step  = adv && (((state == S_SWEEP) && sweep_last) ||
                              ((state == S_RANDOM) && !rand_last));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start)                 state_nxt = S_SPECIAL;
      S_SPECIAL:      if (adv && spec_last)      state_nxt = S_SWEEP;
      S_SWEEP:        if (adv && sweep_last)     state_nxt = S_RANDOM;
      S_RANDOM:       if (adv && rand_last)      state_nxt = S_DONE;
      default:                                   state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    phase = 2'd0;
    done  = 1'b0;
    case (state)
      S_SPECIAL: phase = 2'd1;
      S_SWEEP:   phase = 2'd2;
      S_RANDOM:  phase = 2'd3;
      S_DONE:    done  = 1'b1;
      default:   ;
    endcase
  end

  // Operand following the one currently on op.
  always_comb begin
    op_nxt = op;
    case (state)
      S_SPECIAL: op_nxt = spec_last ? {1'b0, 8'd1, 23'd0} : spec_entry(idx + 4'd1);
      S_SWEEP: begin
        if (!half)           op_nxt = {1'b0, sexp, 23'h7FFFFF};
        else if (sweep_last) op_nxt = rand_op;
        else                 op_nxt = {1'b0, sexp + 8'd1, 23'd0};
      end
      S_RANDOM:  if (!rand_last) op_nxt = rand_op;
      default:   ;
    endcase
  end

  // Generator datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op       <= '0;
      op_valid <= 1'b0;
      count    <= '0;
      idx      <= '0;
      sexp     <= '0;
      half     <= 1'b0;
      rcnt     <= '0;
      lfsr     <= LFSR_SEED;
    end else begin
      count    <= count + {15'd0, op_valid};
      op_valid <= 1'b0;
      if (launch) begin
        op       <= spec_entry(4'd0);
        op_valid <= 1'b1;
        count    <= '0;
        idx      <= '0;
        lfsr     <= LFSR_SEED;
      end else if (adv) begin
        op       <= op_nxt;
        op_valid <= !((state == S_RANDOM) && rand_last);
        if (lfsr_step) lfsr <= lfsr_nxt;
        case (state)
          S_SPECIAL: begin
            if (spec_last) begin
              sexp <= 8'd1;
              half <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
          S_SWEEP: begin
            if (!half)           half <= 1'b1;
            else if (sweep_last) rcnt <= 16'd1;
            else begin
              sexp <= sexp + 8'd1;
              half <= 1'b0;
            end
          end
          S_RANDOM: if (!rand_last) rcnt <= rcnt + 16'd1;
          default:  ;
        endcase
      end
    end
  end

  // Delay line tracks fsqrt, which never stalls, so it ignores hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) dly_op[i] <= '0;
      dly_v <= '0;
    end else begin
      dly_op[0] <= op;
      dly_v[0]  <= op_valid;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        dly_op[i] <= dly_op[i-1];
        dly_v[i]  <= dly_v[i-1];
      end
    end
  end

  assign op_aligned    = dly_op[LATENCY-1];
  assign aligned_valid = dly_v[LATENCY-1];

endmodule

// File: tb/tb_fsqrt_operand_gen.sv
module tb_fsqrt_operand_gen;

  localparam int unsigned LAT  = 2;
  localparam int unsigned RC   = 1024;
  localparam logic [31:0] SEED = 32'hACE12468;
`ifdef FSQRT_GEN_NEG_EN
  localparam int NS = 10;
`else
  localparam int NS = 8;
`endif
  localparam int NTOT = NS + 508 + RC;

  logic        clk, reset, start, hold;
  logic [31:0] op, op_aligned;
  logic        op_valid, aligned_valid, done;
  logic [1:0]  phase;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  fsqrt_operand_gen #(
    .LATENCY   (LAT),
    .RAND_COUNT(RC),
    .LFSR_SEED (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .hold         (hold),
    .op           (op),
    .op_valid     (op_valid),
    .op_aligned   (op_aligned),
    .aligned_valid(aligned_valid),
    .phase        (phase),
    .count        (count),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected operand sequence for a whole run, built straight from the rules.
  logic [31:0] seq [NTOT];
  logic [31:0] spec_tab [10];

  task automatic build_seq();
    logic [31:0] l;
    spec_tab = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                 32'h3F800000, 32'h40800000, 32'h00800000, 32'h7F7FFFFF,
                 32'hBF800000, 32'hFF800000};
    for (int i = 0; i < NS; i++) seq[i] = spec_tab[i];
    for (int e = 1; e <= 254; e++) begin
      seq[NS + 2*(e-1)]     = {1'b0, 8'(e), 23'h000000};
      seq[NS + 2*(e-1) + 1] = {1'b0, 8'(e), 23'h7FFFFF};
    end
    l = SEED;
    for (int k = 0; k < int'(RC); k++) begin
`ifdef FSQRT_GEN_NEG_EN
      seq[NS + 508 + k] = l;
`else
      seq[NS + 508 + k] = {1'b0, l[30:0]};
`endif
      l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    end
  endtask

  // Cycle model: position within the sequence plus a history for alignment.
  bit          m_run   = 0;
  int          m_pos   = 0;
  logic [31:0] m_op    = '0;
  logic        m_valid = 0;
  logic [15:0] m_count = '0;
  logic        m_done  = 0;
  logic [31:0] h_op [LAT] = '{default: '0};
  logic        h_v  [LAT] = '{default: 1'b0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_pos = 0; m_op = '0; m_valid = 0; m_count = '0; m_done = 0;
      for (int i = 0; i < int'(LAT); i++) begin h_op[i] = '0; h_v[i] = 1'b0; end
    end else begin
      for (int i = int'(LAT) - 1; i > 0; i--) begin h_op[i] = h_op[i-1]; h_v[i] = h_v[i-1]; end
      h_op[0] = m_op;
      h_v[0]  = m_valid;
      m_count = m_count + 16'(m_valid);
      if (!m_run) begin
        m_valid = 0;
        if (start) begin
          m_run = 1; m_pos = 0; m_op = seq[0]; m_valid = 1; m_count = '0; m_done = 0;
        end
      end else if (hold) begin
        m_valid = 0;
      end else if (m_pos == NTOT - 1) begin
        m_run = 0; m_done = 1; m_valid = 0;
      end else begin
        m_pos++;
        m_op = seq[m_pos];
        m_valid = 1;
      end
    end
  end

  function automatic logic [1:0] m_phase();
    if (!m_run)               return 2'd0;
    else if (m_pos < NS)      return 2'd1;
    else if (m_pos < NS+508)  return 2'd2;
    else                      return 2'd3;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("op",            op,            m_op);
      chk("op_valid",      32'(op_valid), 32'(m_valid));
      chk("op_aligned",    op_aligned,    h_op[LAT-1]);
      chk("aligned_valid", 32'(aligned_valid), 32'(h_v[LAT-1]));
      chk("phase",         32'(phase),    32'(m_phase()));
      chk("count",         32'(count),    32'(m_count));
      chk("done",          32'(done),     32'(m_done));
    end
  end

  task automatic wait_op(input logic [31:0] val, input logic [1:0] ph, input int budget, input string nm);
    int n = 0;
    while (!(op === val && op_valid === 1'b1 && phase === ph) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, op, val);
    chk({nm, "_v"}, 32'(op_valid), 32'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_op"},    op,                 32'h0);
    chk({nm, "_v"},     32'(op_valid),      32'h0);
    chk({nm, "_al"},    op_aligned,         32'h0);
    chk({nm, "_alv"},   32'(aligned_valid), 32'h0);
    chk({nm, "_phase"}, 32'(phase),         32'h0);
    chk({nm, "_count"}, 32'(count),         32'h0);
    chk({nm, "_done"},  32'(done),          32'h0);
  endtask

  initial begin
    int n;
    build_seq();
    clk = 0; reset = 1; start = 0; hold = 0;
    #1 reset = 0;
    #1 cmp_en = 1;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1;
    repeat (2) @(negedge clk);
    chk("idle_phase", 32'(phase), 32'd0);
    chk("idle_done",  32'(done),  32'd0);

    // SPECIAL entries on consecutive cycles; start mid-run is ignored.
    start = 1;
    @(negedge clk); start = 0;
    chk("sp0_op", op, 32'h00000000);
    chk("sp0_v", 32'(op_valid), 32'd1);
    chk("sp0_phase", 32'(phase), 32'd1);
    chk("sp0_count", 32'(count), 32'd0);
    @(negedge clk); start = 1;
    chk("sp1_op", op, 32'h80000000);
    @(negedge clk); start = 0;
    chk("sp2_op", op, 32'h7F800000);
    chk("al0_op", op_aligned, 32'h00000000);
    chk("al0_v", 32'(aligned_valid), 32'd1);

    wait_op(32'h7F7FFFFF, 2'd1, 20, "sp_last");
    @(negedge clk);
`ifdef FSQRT_GEN_NEG_EN
    chk("neg1", op, 32'hBF800000);
    @(negedge clk);
    chk("neg2", op, 32'hFF800000);
    @(negedge clk);
`endif
    chk("sw_first", op, 32'h00800000);
    chk("sw_phase", 32'(phase), 32'd2);
    @(negedge clk);
    chk("sw_second", op, 32'h00FFFFFF);

    // Stall five cycles on e=0x40, fraction zero (sequence index NS+126).
    wait_op(32'h20000000, 2'd2, 300, "sw_e40");
    chk("sw_e40_count", 32'(count), 32'(NS + 126));
    hold = 1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_v",     32'(op_valid), 32'd0);
      chk("hold_op",    op,            32'h20000000);
      chk("hold_count", 32'(count),    32'(NS + 127));
    end
    hold = 0;
    @(negedge clk);
    chk("post_hold_op", op, 32'h207FFFFF);
    chk("post_hold_v",  32'(op_valid), 32'd1);

    wait_op(32'h7F7FFFFF, 2'd2, 600, "sw_last");
    @(negedge clk);
    chk("rnd_phase", 32'(phase), 32'd3);
`ifdef FSQRT_GEN_NEG_EN
    chk("rnd1", op, 32'hACE12468);
`else
    chk("rnd1", op, 32'h2CE12468);
`endif
    // seed[0]=0, so the first step is a plain shift: 0x56709234.
    @(negedge clk);
    chk("rnd2", op, 32'h56709234);
    hold = 1;
    repeat (3) @(negedge clk);
    hold = 0;

    // Hold start high from late RANDOM through DONE: restart immediately.
    n = 0;
    while (32'(count) < 32'(NTOT - 3) && n < 1200) begin @(negedge clk); n++; end
    start = 1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("done", 32'(done), 32'd1);
    chk("done_count", 32'(count), 32'(NTOT));
    chk("done_phase", 32'(phase), 32'd0);
    hold = 1;
    @(negedge clk);
    chk("restart_op", op, 32'h00000000);
    chk("restart_v", 32'(op_valid), 32'd1);
    chk("restart_phase", 32'(phase), 32'd1);
    chk("restart_count", 32'(count), 32'd0);
    start = 0; hold = 0;

    // Asynchronous reset in the middle of RANDOM.
    n = 0;
    while (phase !== 2'd3 && n < 700) begin @(negedge clk); n++; end
    chk("reach_rnd", 32'(phase), 32'd3);
    repeat (5) @(negedge clk);
    #2 reset = 0;
    #1 chk_zero("arst");
    repeat (2) @(negedge clk);
    chk_zero("arst_hold");
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_phase", 32'(phase), 32'd0);
      chk("post_rst_done",  32'(done),  32'd0);
      chk("post_rst_v",     32'(op_valid), 32'd0);
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
